// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Parameters shared by the switch egress blocks: the metadata
//                word width, the metadata queue depth and the width of the
//                overflow (drop) counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;
  localparam int META_WIDTH      = 32;
  localparam int META_FIFO_DEPTH = 16;
  localparam int DROP_CNT_WIDTH  = 16;
endpackage : switch_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : Simple dual-port storage array. One synchronous write port
//                and one asynchronous (combinational) read port. Contents are
//                not reset.
//  Ports       : clk      - system clock
//                wr_en    - write strobe
//                wr_addr  - write address
//                wr_data  - write data
//                rd_addr  - read address
//                rd_data  - read data (combinational from rd_addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/meta_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : meta_out_fifo
//  Description : Egress metadata queue. Captures one result word per push
//                strobe into a circular buffer and presents the oldest word
//                to software, which pops it with a one-cycle ack. Pushes that
//                arrive while full (with no simultaneous pop) are discarded
//                and optionally counted.
//  Options     : META_FIFO_DROP_CNT_EN - when defined, drop_count counts
//                discarded pushes (saturating at all-ones, cleared by reset
//                or flush). When undefined, drop_count is tied to 0.
//  Ports       : clk            - system clock (rising edge)
//                reset          - synchronous active-high reset
//                fifo_in        - word from the egress validator
//                fifo_in_en     - push strobe
//                flush          - synchronous clear of queue and drop count
//                fifo_out       - head word, 0 when empty
//                fifo_out_valid - queue not empty
//                fifo_out_ack   - pop strobe
//                fifo_count     - current occupancy
//                fifo_full      - occupancy equals DEPTH
//                drop_count     - overflow counter
//  Revision    : 1.0 - initial release
// ============================================================================
module meta_out_fifo
  import switch_pkg::*;
#(
  parameter int WIDTH = META_WIDTH,
  parameter int DEPTH = META_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          fifo_in,
  input  logic                      fifo_in_en,
  input  logic                      flush,
  output logic [WIDTH-1:0]          fifo_out,
  output logic                      fifo_out_valid,
  input  logic                      fifo_out_ack,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      fifo_full,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_wr_en;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full queue is
  // still accepted when it coincides with a pop.
  assign w_pop   = fifo_out_ack & ~w_empty;
  assign w_push  = fifo_in_en & (~w_full | w_pop);

  // Reset and flush override everything, including the memory write.
  assign w_wr_en = w_push & ~flush & ~reset;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_ptr),
    .wr_data (fifo_in),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef META_FIFO_DROP_CNT_EN
  logic                      w_drop;
  logic [DROP_CNT_WIDTH-1:0] r_drop_count;

  assign w_drop = fifo_in_en & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + DROP_CNT_WIDTH'(1);
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

  assign fifo_out       = w_empty ? '0 : w_rd_data;
  assign fifo_out_valid = ~w_empty;
  assign fifo_count     = r_count;
  assign fifo_full      = w_full;

endmodule : meta_out_fifo
`default_nettype wire

// File: tb/tb_meta_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_meta_out_fifo
//  Description : Self-checking bench for meta_out_fifo. A scoreboard queue
//                receives each word the bench expects the DUT to accept;
//                words are popped and compared when software acks.
//  Options     : META_FIFO_DROP_CNT_EN selects the expected drop_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_meta_out_fifo;
  import switch_pkg::*;

  localparam int W = META_WIDTH;
  localparam int D = META_FIFO_DEPTH;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [W-1:0]              fifo_in = '0;
  logic                      fifo_in_en = 1'b0;
  logic                      flush = 1'b0;
  logic [W-1:0]              fifo_out;
  logic                      fifo_out_valid;
  logic                      fifo_out_ack = 1'b0;
  logic [$clog2(D):0]        fifo_count;
  logic                      fifo_full;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] sb[$];
  logic [15:0]  mdrop = 16'd0;

  logic         popped;
  logic [W-1:0] pexp;
  logic [W-1:0] pact;

  meta_out_fifo u_dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_in        (fifo_in),
    .fifo_in_en     (fifo_in_en),
    .flush          (flush),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack   (fifo_out_ack),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_drop();
`ifdef META_FIFO_DROP_CNT_EN
    return mdrop;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [W-1:0] exp_head();
    if (sb.size() == 0) return '0;
    return sb[0];
  endfunction

  // Drives one cycle of stimulus and advances the scoreboard model.
  // pact is the DUT head sampled just before the edge (the word being acked).
  task automatic step(input logic en, input logic [W-1:0] d, input logic ack,
                      input logic fl, output logic pd, output logic [W-1:0] pe,
                      output logic [W-1:0] pa);
    logic full_m;
    logic pop_m;
    fifo_in      = d;
    fifo_in_en   = en;
    fifo_out_ack = ack;
    flush        = fl;
    pa = fifo_out;
    pd = 1'b0;
    pe = '0;
    if (fl) begin
      sb.delete();
      mdrop = 16'd0;
    end else begin
      full_m = (sb.size() == D);
      pop_m  = ack && (sb.size() != 0);
      if (pop_m) begin
        pe = sb.pop_front();
        pd = 1'b1;
      end
      if (en) begin
        if (!full_m || pop_m) sb.push_back(d);
        else if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    fifo_in_en   = 1'b0;
    fifo_out_ack = 1'b0;
    flush        = 1'b0;
    fifo_in      = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    mdrop = 16'd0;
    checks++; if (fifo_out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", fifo_out); end
    checks++; if (fifo_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fifo_out_valid); end
    checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_single();
    step(1'b1, 32'hA000_0001, 1'b0, 1'b0, popped, pexp, pact);
    checks++; if (fifo_out !== 32'hA000_0001) begin failures++; $display("FAIL single_out got=%h exp=a0000001", fifo_out); end
    checks++; if (fifo_out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", fifo_out_valid); end
    checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
    checks++; if (!popped || pact !== pexp) begin failures++; $display("FAIL single_pop got=%h exp=%h", pact, pexp); end
    checks++; if (fifo_out_valid !== 1'b0 || fifo_out !== '0) begin failures++; $display("FAIL single_empty got=%b/%h exp=0/0", fifo_out_valid, fifo_out); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, popped, pexp, pact);
    step(1'b1, 32'h200, 1'b0, 1'b0, popped, pexp, pact);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", fifo_full); end
    checks++; if (fifo_count !== 5'(D)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", fifo_count, D); end
    checks++; if (drop_count !== exp_drop()) begin failures++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_count, exp_drop()); end
    for (int i = 0; i < D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
      checks++; if (!popped || pact !== pexp || pexp !== 32'h100 + i) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, pact, 32'h100 + i); end
    end
    checks++; if (fifo_count !== 5'd0 || fifo_out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0d/%b exp=0/0", fifo_count, fifo_out_valid); end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] d_before;
    logic [W-1:0] last;
    for (int i = 0; i < D; i++) step(1'b1, 32'h400 + i, 1'b0, 1'b0, popped, pexp, pact);
    d_before = drop_count;
    step(1'b1, 32'h300, 1'b1, 1'b0, popped, pexp, pact);
    checks++; if (!popped || pact !== pexp) begin failures++; $display("FAIL fpp_pop got=%h exp=%h", pact, pexp); end
    checks++; if (fifo_count !== 5'(D) || fifo_full !== 1'b1) begin failures++; $display("FAIL fpp_count got=%0d exp=%0d", fifo_count, D); end
    checks++; if (drop_count !== d_before) begin failures++; $display("FAIL fpp_drop got=%0d exp=%0d", drop_count, d_before); end
    last = '0;
    while (sb.size() > 0) begin
      step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
      checks++; if (pact !== pexp) begin failures++; $display("FAIL fpp_drain got=%h exp=%h", pact, pexp); end
      last = pact;
    end
    checks++; if (last !== 32'h300) begin failures++; $display("FAIL fpp_last got=%h exp=300", last); end
  endtask

  task automatic test_empty_pushack();
    step(1'b1, 32'h55, 1'b1, 1'b0, popped, pexp, pact);
    checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL epa_count got=%0d exp=1", fifo_count); end
    checks++; if (fifo_out !== 32'h55) begin failures++; $display("FAIL epa_out got=%h exp=55", fifo_out); end
    step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
    checks++; if (pact !== pexp) begin failures++; $display("FAIL epa_pop got=%h exp=%h", pact, pexp); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
      checks++; if (fifo_count !== 5'd0 || fifo_out_valid !== 1'b0 || fifo_out !== '0) begin failures++; $display("FAIL epa_idle[%0d] got=%0d/%b/%h exp=0/0/0", i, fifo_count, fifo_out_valid, fifo_out); end
    end
  endtask

  task automatic test_wrap();
    logic ack;
    for (int i = 0; i < 40; i++) begin
      ack = ($urandom_range(0, 3) != 0);
      step(1'b1, $urandom, ack, 1'b0, popped, pexp, pact);
      if (popped) begin
        checks++; if (pact !== pexp) begin failures++; $display("FAIL wrap_pop[%0d] got=%h exp=%h", i, pact, pexp); end
      end
      checks++; if (fifo_count !== 5'(sb.size()) || fifo_count > 5'(D)) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, fifo_count, sb.size()); end
    end
    while (sb.size() > 0) begin
      step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
      checks++; if (pact !== pexp) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", pact, pexp); end
    end
    checks++; if (drop_count !== exp_drop()) begin failures++; $display("FAIL wrap_drop got=%0d exp=%0d", drop_count, exp_drop()); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < D + 2; i++) step(1'b1, 32'h600 + i, 1'b0, 1'b0, popped, pexp, pact);
    for (int i = 0; i < D - 5; i++) step(1'b0, '0, 1'b1, 1'b0, popped, pexp, pact);
    checks++; if (fifo_count !== 5'd5 || drop_count !== exp_drop()) begin failures++; $display("FAIL flush_pre got=%0d/%0d exp=5/%0d", fifo_count, drop_count, exp_drop()); end
    step(1'b1, 32'hDEAD, 1'b1, 1'b1, popped, pexp, pact);
    checks++; if (fifo_count !== 5'd0 || fifo_out_valid !== 1'b0 || fifo_out !== '0) begin failures++; $display("FAIL flush_state got=%0d/%b/%h exp=0/0/0", fifo_count, fifo_out_valid, fifo_out); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL flush_drop got=%0d exp=0", drop_count); end
    step(1'b1, 32'h77, 1'b0, 1'b0, popped, pexp, pact);
    checks++; if (fifo_out !== 32'h77 || fifo_count !== 5'd1) begin failures++; $display("FAIL flush_after got=%h/%0d exp=77/1", fifo_out, fifo_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h900 + i, 1'b0, 1'b0, popped, pexp, pact);
    fifo_in = 32'hBEEF; fifo_in_en = 1'b1; fifo_out_ack = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; fifo_in_en = 1'b0; fifo_out_ack = 1'b0; fifo_in = '0;
    sb.delete();
    mdrop = 16'd0;
    checks++; if (fifo_count !== 5'd0 || fifo_out_valid !== 1'b0 || drop_count !== 16'd0) begin failures++; $display("FAIL rstmid got=%0d/%b/%0d exp=0/0/0", fifo_count, fifo_out_valid, drop_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_empty_pushack();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_meta_out_fifo
`default_nettype wire
